// File: rtl/alu_req_scheduler.sv
// Two-requester front end for a shared multi-cycle ALU: round-robin grant, one
// operation in flight, latency chosen per command, result held until taken.
//
// state   | meaning
// S_IDLE  | waiting for a request; req_ready offered to the granted requester
// S_ISSUE | latched operands on alu_*, alu_ce pulsed, latency counter loaded
// S_WAIT  | counting down ALU latency; alu_res captured when the counter hits 1
// S_RESP  | rsp_valid held for the granted requester until its rsp_ready
module alu_req_scheduler #(
    parameter int DATA_WIDTH = 8,
    parameter int CMD_WIDTH  = 4,
    parameter int LAT_ARITH  = 1,
    parameter int LAT_MUL    = 3,
    parameter int MUL_CMD0   = 9,
    parameter int MUL_CMD1   = 10
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_opa,
    input  logic [2*DATA_WIDTH-1:0] req_opb,
    input  logic [2*CMD_WIDTH-1:0]  req_cmd,
    input  logic [1:0]              req_mode,
    input  logic [1:0]              req_cin,
    input  logic [3:0]              req_inp_valid,
    output logic                    alu_ce,
    output logic                    alu_mode,
    output logic                    alu_cin,
    output logic [DATA_WIDTH-1:0]   alu_opa,
    output logic [DATA_WIDTH-1:0]   alu_opb,
    output logic [CMD_WIDTH-1:0]    alu_cmd,
    output logic [1:0]              alu_inp_valid,
    input  logic [2*DATA_WIDTH-1:0] alu_res,
    output logic [1:0]              rsp_valid,
    input  logic [1:0]              rsp_ready,
    output logic [2*DATA_WIDTH-1:0] rsp_res
);

    localparam int LAT_MAX = (LAT_MUL > LAT_ARITH) ? LAT_MUL : LAT_ARITH;
    localparam int CNT_W   = (LAT_MAX < 2) ? 1 : $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

    state_t                  r_state;
    logic                    r_ptr;
    logic                    r_gnt;
    logic [CNT_W-1:0]        r_cnt;
    logic [DATA_WIDTH-1:0]   r_opa;
    logic [DATA_WIDTH-1:0]   r_opb;
    logic [CMD_WIDTH-1:0]    r_cmd;
    logic                    r_mode;
    logic                    r_cin;
    logic [1:0]              r_alu_inp_valid;
    logic                    r_alu_ce;
    logic [1:0]              r_rsp_valid;
    logic [2*DATA_WIDTH-1:0] r_rsp_res;

    logic                    w_gnt_id;
    logic [1:0]              w_req_ready;
    logic                    w_accept;
    logic                    w_is_mul;
    logic                    w_rsp_take;
    logic [DATA_WIDTH-1:0]   w_sel_opa;
    logic [DATA_WIDTH-1:0]   w_sel_opb;
    logic [CMD_WIDTH-1:0]    w_sel_cmd;
    logic [1:0]              w_sel_inp_valid;

    // A lone requester wins outright; the pointer only breaks ties.
    always_comb begin
        w_gnt_id = r_ptr;
        if (req_valid == 2'b01) begin
            w_gnt_id = 1'b0;
        end else if (req_valid == 2'b10) begin
            w_gnt_id = 1'b1;
        end
        w_req_ready = 2'b00;
        // rst gating keeps req_ready low while reset is held with requests pending
        if (rst && (r_state == S_IDLE) && (req_valid != 2'b00)) begin
            w_req_ready = w_gnt_id ? 2'b10 : 2'b01;
        end
    end

    assign w_accept        = |(req_valid & w_req_ready);
    assign w_sel_opa       = w_gnt_id ? req_opa[2*DATA_WIDTH-1:DATA_WIDTH] : req_opa[DATA_WIDTH-1:0];
    assign w_sel_opb       = w_gnt_id ? req_opb[2*DATA_WIDTH-1:DATA_WIDTH] : req_opb[DATA_WIDTH-1:0];
    assign w_sel_cmd       = w_gnt_id ? req_cmd[2*CMD_WIDTH-1:CMD_WIDTH] : req_cmd[CMD_WIDTH-1:0];
    assign w_sel_inp_valid = w_gnt_id ? req_inp_valid[3:2] : req_inp_valid[1:0];
    assign w_is_mul        = r_mode && ((r_cmd == CMD_WIDTH'(MUL_CMD0)) || (r_cmd == CMD_WIDTH'(MUL_CMD1)));
    assign w_rsp_take      = r_gnt ? rsp_ready[1] : rsp_ready[0];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state         <= S_IDLE;
            r_ptr           <= 1'b0;
            r_gnt           <= 1'b0;
            r_cnt           <= '0;
            r_opa           <= '0;
            r_opb           <= '0;
            r_cmd           <= '0;
            r_mode          <= 1'b0;
            r_cin           <= 1'b0;
            r_alu_inp_valid <= 2'b00;
            r_alu_ce        <= 1'b0;
            r_rsp_valid     <= 2'b00;
            r_rsp_res       <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_opa           <= w_sel_opa;
                        r_opb           <= w_sel_opb;
                        r_cmd           <= w_sel_cmd;
                        r_mode          <= w_gnt_id ? req_mode[1] : req_mode[0];
                        r_cin           <= w_gnt_id ? req_cin[1] : req_cin[0];
                        r_alu_inp_valid <= w_sel_inp_valid;
                        r_gnt           <= w_gnt_id;
                        r_ptr           <= ~w_gnt_id;
                        r_alu_ce        <= 1'b1;
                        r_state         <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_alu_ce <= 1'b0;
                    r_cnt    <= w_is_mul ? CNT_W'(LAT_MUL) : CNT_W'(LAT_ARITH);
                    r_state  <= S_WAIT;
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - CNT_W'(1);
                    if (r_cnt <= CNT_W'(1)) begin
                        r_rsp_res       <= alu_res;
                        r_rsp_valid     <= r_gnt ? 2'b10 : 2'b01;
                        r_alu_inp_valid <= 2'b00;
                        r_state         <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (w_rsp_take) begin
                        r_rsp_valid <= 2'b00;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign req_ready     = w_req_ready;
    assign alu_ce        = r_alu_ce;
    assign alu_mode      = r_mode;
    assign alu_cin       = r_cin;
    assign alu_opa       = r_opa;
    assign alu_opb       = r_opb;
    assign alu_cmd       = r_cmd;
    assign alu_inp_valid = r_alu_inp_valid;
    assign rsp_valid     = r_rsp_valid;
    assign rsp_res       = r_rsp_res;

endmodule

// File: tb/tb_alu_req_scheduler.sv
// Bench for alu_req_scheduler: directed vector table, reset/contention sequences,
// and randomized traffic against a round-robin + latency-aware ALU model.
module tb_alu_req_scheduler;

    typedef struct {
        logic [7:0] opa;
        logic [7:0] opb;
        logic [3:0] cmd;
        logic       mode;
        logic       cin;
        logic [1:0] iv;
    } req_t;

    typedef struct {
        int          id;
        req_t        r;
        int          lat;
        logic [15:0] res;
        int          hold;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [1:0]  req_valid = '0;
    logic [1:0]  req_ready;
    logic [15:0] req_opa = '0;
    logic [15:0] req_opb = '0;
    logic [7:0]  req_cmd = '0;
    logic [1:0]  req_mode = '0;
    logic [1:0]  req_cin = '0;
    logic [3:0]  req_inp_valid = '0;
    logic        alu_ce;
    logic        alu_mode;
    logic        alu_cin;
    logic [7:0]  alu_opa;
    logic [7:0]  alu_opb;
    logic [3:0]  alu_cmd;
    logic [1:0]  alu_inp_valid;
    logic [15:0] alu_res;
    logic [1:0]  rsp_valid;
    logic [1:0]  rsp_ready = '0;
    logic [15:0] rsp_res;

    int n_tests = 0;
    int n_fail  = 0;
    logic [7:0] since = 8'd0;

    always #5 clk = ~clk;

    alu_req_scheduler #(
        .DATA_WIDTH(8), .CMD_WIDTH(4), .LAT_ARITH(1), .LAT_MUL(3), .MUL_CMD0(9), .MUL_CMD1(10)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_opa(req_opa), .req_opb(req_opb), .req_cmd(req_cmd),
        .req_mode(req_mode), .req_cin(req_cin), .req_inp_valid(req_inp_valid),
        .alu_ce(alu_ce), .alu_mode(alu_mode), .alu_cin(alu_cin),
        .alu_opa(alu_opa), .alu_opb(alu_opb), .alu_cmd(alu_cmd),
        .alu_inp_valid(alu_inp_valid), .alu_res(alu_res),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_res(rsp_res)
    );

    function automatic logic [15:0] alu_ref(input logic [7:0] a, input logic [7:0] b,
                                            input logic [3:0] c, input logic m, input logic ci);
        if (!m) return {8'h00, a & b};
        case (c)
            4'd0:    return 16'(a) + 16'(b) + 16'(ci);
            4'd1:    return 16'(a) - 16'(b);
            4'd9:    return 16'(a) * 16'(b);
            4'd10:   return 16'(a) * 16'(a);
            default: return {8'h00, a ^ b};
        endcase
    endfunction

    function automatic int lat_ref(input logic m, input logic [3:0] c);
        return (m && (c == 4'd9 || c == 4'd10)) ? 3 : 1;
    endfunction

    // Reference ALU: the true result appears only exactly LAT cycles after alu_ce.
    always @(posedge clk) begin
        if (alu_ce) since <= 8'd1;
        else if (since != 8'd255) since <= since + 8'd1;
    end
    assign alu_res = (int'(since) == lat_ref(alu_mode, alu_cmd))
                   ?  alu_ref(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin)
                   : ~alu_ref(alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin);

    function automatic req_t mk(input int a, input int b, input int c, input int m, input int ci, input int iv);
        req_t r;
        r.opa = 8'(a); r.opb = 8'(b); r.cmd = 4'(c);
        r.mode = 1'(m); r.cin = 1'(ci); r.iv = 2'(iv);
        return r;
    endfunction

    function automatic req_t rnd_req();
        req_t r;
        int   k;
        k = $urandom_range(0, 4);
        r.opa  = 8'($urandom);
        r.opb  = 8'($urandom);
        r.cmd  = (k == 0) ? 4'd0 : (k == 1) ? 4'd1 : (k == 2) ? 4'd9 : (k == 3) ? 4'd10 : 4'($urandom);
        r.mode = ($urandom_range(0, 3) != 0);
        r.cin  = 1'($urandom);
        r.iv   = 2'($urandom);
        return r;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Entered just after a negedge with the DUT in IDLE; returns after a negedge in IDLE.
    task automatic txn(input logic [1:0] vmask, input req_t r0, input req_t r1, input int gnt,
                       input int lat, input logic [15:0] res, input int hold);
        req_t        g;
        logic [23:0] exp_f;
        logic [15:0] held;
        logic [1:0]  gbit;
        int          c;
        logic        bad;
        g     = gnt ? r1 : r0;
        gbit  = gnt ? 2'b10 : 2'b01;
        exp_f = {g.opa, g.opb, g.cmd, g.mode, g.cin, g.iv};
        req_opa = {r1.opa, r0.opa};   req_opb = {r1.opb, r0.opb};
        req_cmd = {r1.cmd, r0.cmd};   req_mode = {r1.mode, r0.mode};
        req_cin = {r1.cin, r0.cin};   req_inp_valid = {r1.iv, r0.iv};
        req_valid = vmask;
        #1;
        chk("req_ready_grant", req_ready, gbit);
        @(posedge clk); #1;
        req_opa = 16'($urandom); req_opb = 16'($urandom); req_cmd = 8'($urandom);
        req_mode = 2'($urandom); req_cin = 2'($urandom); req_inp_valid = 4'($urandom);
        @(negedge clk);
        chk("issue_ce", alu_ce, 1);
        chk("issue_fields", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid}, exp_f);
        chk("issue_ready", req_ready, 0);
        bad = 1'b0;
        c = 1;
        while (rsp_valid == 2'b00 && c < 20) begin
            @(negedge clk);
            c++;
            if (rsp_valid == 2'b00 &&
                (alu_ce || {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, alu_inp_valid} != exp_f))
                bad = 1'b1;
        end
        chk("wait_stable", bad, 0);
        chk("rsp_latency", c, 2 + lat);
        chk("rsp_valid", rsp_valid, gbit);
        chk("rsp_res", rsp_res, res);
        chk("resp_alu_idle", {alu_ce, alu_inp_valid}, 0);
        held = rsp_res;
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            rsp_ready = ~gbit;
            req_valid = 2'b11;
            @(negedge clk);
            if (rsp_valid != gbit || rsp_res != held || req_ready != 2'b00) bad = 1'b1;
        end
        if (hold > 0) chk("backpressure", bad, 0);
        @(posedge clk); #1;
        rsp_ready = gbit;
        req_valid = 2'b00;
        @(negedge clk);
        @(posedge clk); #1;
        rsp_ready = 2'b00;
        @(negedge clk);
        chk("rsp_clear", rsp_valid, 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        req_t junk;
        req_t r0, r1, g;
        int   ptr, gnt;
        logic [1:0] vm;
        logic bad;

        tbl[0] = '{0, mk(5, 3, 0, 1, 0, 3),     1, 16'd8,     0};
        tbl[1] = '{1, mk(4, 6, 9, 1, 0, 1),     3, 16'd24,    10};
        tbl[2] = '{0, mk(200, 100, 0, 1, 1, 2), 1, 16'd301,   0};
        tbl[3] = '{1, mk(7, 9, 10, 1, 0, 3),    3, 16'd49,    2};
        tbl[4] = '{0, mk(13, 7, 9, 0, 0, 1),    1, 16'd5,     0};
        tbl[5] = '{1, mk(10, 3, 1, 1, 0, 2),    1, 16'd7,     1};
        tbl[6] = '{0, mk(3, 5, 1, 1, 0, 3),     1, 16'd65534, 0};
        tbl[7] = '{1, mk(255, 255, 9, 1, 0, 0), 3, 16'd65025, 0};

        // Reset with both requesters asserting: everything must stay quiet.
        rst = 1'b0;
        req_valid = 2'b11;
        req_opa = 16'hA5A5; req_opb = 16'h5A5A; req_inp_valid = 4'hF;
        repeat (3) @(negedge clk);
        chk("reset_ctrl", {req_ready, alu_ce, alu_inp_valid, rsp_valid}, 0);
        chk("reset_data", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, rsp_res}, 0);
        req_valid = 2'b00;
        rst = 1'b1;

        // First accept lands on the first edge after reset release.
        for (int i = 0; i < 8; i++) begin
            junk = rnd_req();
            if (tbl[i].id == 0)
                txn(2'b01, tbl[i].r, junk, 0, tbl[i].lat, tbl[i].res, tbl[i].hold);
            else
                txn(2'b10, junk, tbl[i].r, 1, tbl[i].lat, tbl[i].res, tbl[i].hold);
        end

        // Reset in the first WAIT cycle of a multiply.
        r0 = mk(6, 7, 9, 1, 0, 3);
        req_opa = {8'd0, r0.opa}; req_opb = {8'd0, r0.opb}; req_cmd = {4'd0, r0.cmd};
        req_mode = 2'b01; req_cin = 2'b00; req_inp_valid = 4'h3;
        req_valid = 2'b01;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_mid_ctrl", {req_ready, alu_ce, alu_inp_valid, rsp_valid}, 0);
        chk("rst_mid_data", {alu_opa, alu_opb, alu_cmd, alu_mode, alu_cin, rsp_res}, 0);
        req_valid = 2'b00;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        bad = 1'b0;
        repeat (6) begin
            @(negedge clk);
            if (rsp_valid != 2'b00) bad = 1'b1;
        end
        chk("no_rsp_after_rst", bad, 0);

        // Contention from a fresh pointer, then a lone requester against pointer=1.
        g = mk(1, 2, 0, 1, 0, 1);
        txn(2'b11, g, rnd_req(), 0, 1, 16'd3, 0);
        g = mk(3, 4, 9, 1, 0, 2);
        txn(2'b11, rnd_req(), g, 1, 3, 16'd12, 0);
        g = mk(8, 8, 0, 1, 1, 3);
        txn(2'b11, g, rnd_req(), 0, 1, 16'd17, 0);
        g = mk(2, 9, 0, 1, 0, 1);
        txn(2'b01, g, rnd_req(), 0, 1, 16'd11, 0);
        g = mk(12, 12, 10, 1, 0, 2);
        txn(2'b11, rnd_req(), g, 1, 3, 16'd144, 0);

        // Randomized traffic; pointer now points back at requester 0.
        ptr = 0;
        for (int i = 0; i < 40; i++) begin
            vm = 2'($urandom_range(1, 3));
            r0 = rnd_req();
            r1 = rnd_req();
            if (vm == 2'b01) gnt = 0;
            else if (vm == 2'b10) gnt = 1;
            else gnt = ptr;
            ptr = 1 - gnt;
            g = gnt ? r1 : r0;
            txn(vm, r0, r1, gnt, lat_ref(g.mode, g.cmd),
                alu_ref(g.opa, g.opb, g.cmd, g.mode, g.cin), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
